// File: rtl/se_qubip_axil_pkg.sv
// se_qubip_axil_pkg
// Shared types and constants for the SE_QUBIP S00_AXI AXI4-Lite register file.
//   AXI_RESP_OKAY / AXI_RESP_SLVERR : BRESP/RRESP encodings
//   wr_state_e                      : write-channel FSM states
//   rd_state_e                      : read-channel FSM states
//   word_t                          : 32-bit register word
package se_qubip_axil_pkg;

   localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
   localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;

   typedef logic [31:0] word_t;

   typedef enum logic [1:0] {
      WrIdle,
      WrHaveAw,
      WrHaveW,
      WrResp
   } wr_state_e;

   typedef enum logic {
      RdIdle,
      RdValid
   } rd_state_e;

endpackage

// File: rtl/se_qubip_axil_regs.sv
// se_qubip_axil_regs
// AXI4-Lite slave register file (S00_AXI control port of SE_QUBIP).
// Holds NUM_REGS 32-bit registers, writable with byte strobes and readable by
// the host, and exposes them plus per-register write pulses to the core.
//
// Ports:
//   s00_axi_aclk, s00_axi_aresetn : clock, async active-low reset
//   s00_axi_aw*/w*/b*             : write address / data / response channels
//   s00_axi_ar*/r*                : read address / data channels
//   reg_o                         : register k at bits [32k+31:32k]
//   wr_pulse_o                    : one-cycle pulse per register, coincident
//                                   with the first cycle of bvalid
//
// Build option: define SE_QUBIP_AXIL_SLVERR_EN to answer out-of-range
// accesses with SLVERR instead of OKAY.
module se_qubip_axil_regs
   import se_qubip_axil_pkg::*;
#(
   parameter int unsigned C_S_AXI_DATA_WIDTH = 32,
   parameter int unsigned C_S_AXI_ADDR_WIDTH = 6,
   parameter int unsigned NUM_REGS           = 4
) (
   input  logic                            s00_axi_aclk,
   input  logic                            s00_axi_aresetn,
   input  logic [C_S_AXI_ADDR_WIDTH-1:0]   s00_axi_awaddr,
   input  logic [2:0]                      s00_axi_awprot,
   input  logic                            s00_axi_awvalid,
   output logic                            s00_axi_awready,
   input  logic [C_S_AXI_DATA_WIDTH-1:0]   s00_axi_wdata,
   input  logic [C_S_AXI_DATA_WIDTH/8-1:0] s00_axi_wstrb,
   input  logic                            s00_axi_wvalid,
   output logic                            s00_axi_wready,
   output logic [1:0]                      s00_axi_bresp,
   output logic                            s00_axi_bvalid,
   input  logic                            s00_axi_bready,
   input  logic [C_S_AXI_ADDR_WIDTH-1:0]   s00_axi_araddr,
   input  logic [2:0]                      s00_axi_arprot,
   input  logic                            s00_axi_arvalid,
   output logic                            s00_axi_arready,
   output logic [C_S_AXI_DATA_WIDTH-1:0]   s00_axi_rdata,
   output logic [1:0]                      s00_axi_rresp,
   output logic                            s00_axi_rvalid,
   input  logic                            s00_axi_rready,
   output logic [NUM_REGS*32-1:0]          reg_o,
   output logic [NUM_REGS-1:0]             wr_pulse_o
);

   localparam int unsigned IDX_W  = C_S_AXI_ADDR_WIDTH - 2;
   localparam int unsigned STRB_W = C_S_AXI_DATA_WIDTH / 8;

   // Ready outputs stay low until the first edge after reset release.
   logic rdy_en_q;

   // Write path
   wr_state_e             wr_st_q, wr_st_d;
   logic                  aw_hs, w_hs, commit;
   logic [IDX_W-1:0]      aw_idx_q, wr_idx;
   word_t                 w_data_q, wr_data;
   logic [STRB_W-1:0]     w_strb_q, wr_strb;
   logic [1:0]            bresp_q, wr_resp;
   logic [NUM_REGS-1:0]   wr_pulse_q, pulse_d;
   word_t                 regs_q [NUM_REGS];
   word_t                 regs_d [NUM_REGS];

   // Read path
   rd_state_e             rd_st_q, rd_st_d;
   logic                  ar_hs;
   logic [IDX_W-1:0]      rd_idx;
   word_t                 rd_word, rdata_q;
   logic [1:0]            rresp_q, rd_resp;

   logic unused_ok;
   assign unused_ok = ^{s00_axi_awprot, s00_axi_arprot,
                        s00_axi_awaddr[1:0], s00_axi_araddr[1:0]};

   always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
      if (!s00_axi_aresetn) rdy_en_q <= 1'b0;
      else                  rdy_en_q <= 1'b1;
   end

   // ---------------------------------------------------------------------
   // Write channel
   // ---------------------------------------------------------------------
   assign s00_axi_awready = rdy_en_q && ((wr_st_q == WrIdle) || (wr_st_q == WrHaveW));
   assign s00_axi_wready  = rdy_en_q && ((wr_st_q == WrIdle) || (wr_st_q == WrHaveAw));
   assign s00_axi_bvalid  = (wr_st_q == WrResp);
   assign s00_axi_bresp   = bresp_q;
   assign aw_hs           = s00_axi_awvalid && s00_axi_awready;
   assign w_hs            = s00_axi_wvalid && s00_axi_wready;

   always_comb begin
      wr_st_d = wr_st_q;
      commit  = 1'b0;
      unique case (wr_st_q)
         WrIdle: begin
            if (aw_hs && w_hs) commit  = 1'b1;
            else if (aw_hs)    wr_st_d = WrHaveAw;
            else if (w_hs)     wr_st_d = WrHaveW;
         end
         WrHaveAw: if (w_hs)  commit = 1'b1;
         WrHaveW:  if (aw_hs) commit = 1'b1;
         WrResp:   if (s00_axi_bready) wr_st_d = WrIdle;
         default:  wr_st_d = WrIdle;
      endcase
      if (commit) wr_st_d = WrResp;
   end

   always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
      if (!s00_axi_aresetn) wr_st_q <= WrIdle;
      else                  wr_st_q <= wr_st_d;
   end

   // Whichever half arrived earlier comes from its latch; the other is live.
   assign wr_idx  = (wr_st_q == WrHaveAw) ? aw_idx_q : s00_axi_awaddr[C_S_AXI_ADDR_WIDTH-1:2];
   assign wr_data = (wr_st_q == WrHaveW)  ? w_data_q : s00_axi_wdata;
   assign wr_strb = (wr_st_q == WrHaveW)  ? w_strb_q : s00_axi_wstrb;

   // Out-of-range indices match no k, so they update nothing and pulse nothing.
   always_comb begin
      regs_d  = regs_q;
      pulse_d = '0;
      for (int unsigned k = 0; k < NUM_REGS; k++) begin
         if (commit && (wr_idx == IDX_W'(k))) begin
            pulse_d[k] = 1'b1;
            for (int unsigned b = 0; b < STRB_W; b++) begin
               if (wr_strb[b]) regs_d[k][8*b +: 8] = wr_data[8*b +: 8];
            end
         end
      end
   end

`ifdef SE_QUBIP_AXIL_SLVERR_EN
   assign wr_resp = (32'(wr_idx) < NUM_REGS) ? AXI_RESP_OKAY : AXI_RESP_SLVERR;
   assign rd_resp = (32'(rd_idx) < NUM_REGS) ? AXI_RESP_OKAY : AXI_RESP_SLVERR;
`else
   assign wr_resp = AXI_RESP_OKAY;
   assign rd_resp = AXI_RESP_OKAY;
`endif

   always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
      if (!s00_axi_aresetn) begin
         aw_idx_q   <= '0;
         w_data_q   <= '0;
         w_strb_q   <= '0;
         bresp_q    <= AXI_RESP_OKAY;
         wr_pulse_q <= '0;
         for (int unsigned k = 0; k < NUM_REGS; k++) regs_q[k] <= '0;
      end else begin
         if (aw_hs) aw_idx_q <= s00_axi_awaddr[C_S_AXI_ADDR_WIDTH-1:2];
         if (w_hs) begin
            w_data_q <= s00_axi_wdata;
            w_strb_q <= s00_axi_wstrb;
         end
         if (commit) bresp_q <= wr_resp;
         wr_pulse_q <= pulse_d;
         regs_q     <= regs_d;
      end
   end

   assign wr_pulse_o = wr_pulse_q;

   always_comb begin
      reg_o = '0;
      for (int unsigned k = 0; k < NUM_REGS; k++) reg_o[32*k +: 32] = regs_q[k];
   end

   // ---------------------------------------------------------------------
   // Read channel
   // ---------------------------------------------------------------------
   assign s00_axi_arready = rdy_en_q && (rd_st_q == RdIdle);
   assign s00_axi_rvalid  = (rd_st_q == RdValid);
   assign s00_axi_rdata   = rdata_q;
   assign s00_axi_rresp   = rresp_q;
   assign ar_hs           = s00_axi_arvalid && s00_axi_arready;
   assign rd_idx          = s00_axi_araddr[C_S_AXI_ADDR_WIDTH-1:2];

   always_comb begin
      rd_st_d = rd_st_q;
      unique case (rd_st_q)
         RdIdle:  if (ar_hs)          rd_st_d = RdValid;
         RdValid: if (s00_axi_rready) rd_st_d = RdIdle;
         default: rd_st_d = RdIdle;
      endcase
   end

   // Reads the pre-edge register values, so a same-edge write is not seen.
   always_comb begin
      rd_word = '0;
      for (int unsigned k = 0; k < NUM_REGS; k++) begin
         if (rd_idx == IDX_W'(k)) rd_word = regs_q[k];
      end
   end

   always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
      if (!s00_axi_aresetn) begin
         rd_st_q <= RdIdle;
         rdata_q <= '0;
         rresp_q <= AXI_RESP_OKAY;
      end else begin
         rd_st_q <= rd_st_d;
         if (ar_hs) begin
            rdata_q <= rd_word;
            rresp_q <= rd_resp;
         end
      end
   end

endmodule

// File: tb/tb_se_qubip_axil_regs.sv
// tb_se_qubip_axil_regs
// Directed self-checking bench for se_qubip_axil_regs (default 4 registers,
// 6-bit address). Stimulus is driven and outputs sampled 1 time unit after
// each rising edge.
module tb_se_qubip_axil_regs;
   import se_qubip_axil_pkg::*;

   localparam int unsigned AW = 6;
   localparam int unsigned NR = 4;

`ifdef SE_QUBIP_AXIL_SLVERR_EN
   localparam logic [1:0] OOR_RESP = AXI_RESP_SLVERR;
`else
   localparam logic [1:0] OOR_RESP = AXI_RESP_OKAY;
`endif

   logic            clk = 1'b0;
   logic            rst_n;
   logic [AW-1:0]   awaddr, araddr;
   logic [2:0]      awprot, arprot;
   logic            awvalid, awready, wvalid, wready, bvalid, bready;
   logic            arvalid, arready, rvalid, rready;
   logic [31:0]     wdata, rdata;
   logic [3:0]      wstrb;
   logic [1:0]      bresp, rresp;
   logic [NR*32-1:0] reg_o;
   logic [NR-1:0]   wr_pulse_o;

   always #5 clk = ~clk;

   se_qubip_axil_regs #(
      .C_S_AXI_DATA_WIDTH (32),
      .C_S_AXI_ADDR_WIDTH (AW),
      .NUM_REGS           (NR)
   ) dut (
      .s00_axi_aclk    (clk),
      .s00_axi_aresetn (rst_n),
      .s00_axi_awaddr  (awaddr),
      .s00_axi_awprot  (awprot),
      .s00_axi_awvalid (awvalid),
      .s00_axi_awready (awready),
      .s00_axi_wdata   (wdata),
      .s00_axi_wstrb   (wstrb),
      .s00_axi_wvalid  (wvalid),
      .s00_axi_wready  (wready),
      .s00_axi_bresp   (bresp),
      .s00_axi_bvalid  (bvalid),
      .s00_axi_bready  (bready),
      .s00_axi_araddr  (araddr),
      .s00_axi_arprot  (arprot),
      .s00_axi_arvalid (arvalid),
      .s00_axi_arready (arready),
      .s00_axi_rdata   (rdata),
      .s00_axi_rresp   (rresp),
      .s00_axi_rvalid  (rvalid),
      .s00_axi_rready  (rready),
      .reg_o           (reg_o),
      .wr_pulse_o      (wr_pulse_o)
   );

   int unsigned n_checks = 0;
   int unsigned n_pass   = 0;
   int unsigned pulse_cnt [NR] = '{default: 0};

   always @(posedge clk) begin
      if (rst_n) begin
         for (int k = 0; k < NR; k++) if (wr_pulse_o[k]) pulse_cnt[k] <= pulse_cnt[k] + 1;
      end
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
   endtask

   function automatic logic [31:0] word(input int k);
      return reg_o[32*k +: 32];
   endfunction

   // All tasks enter and leave 1 unit after a rising edge.
   task automatic axi_write(input logic [AW-1:0] addr, input logic [31:0] data,
                            input logic [3:0] strb, output logic [1:0] resp);
      bit aw_done = 0, w_done = 0, aw_hit, w_hit;
      awaddr = addr; wdata = data; wstrb = strb;
      awvalid = 1'b1; wvalid = 1'b1; bready = 1'b1;
      for (int i = 0; i < 20 && !(aw_done && w_done); i++) begin
         aw_hit = awvalid && awready;
         w_hit  = wvalid && wready;
         @(posedge clk); #1;
         if (aw_hit) begin awvalid = 1'b0; aw_done = 1; end
         if (w_hit)  begin wvalid  = 1'b0; w_done  = 1; end
      end
      if (!(aw_done && w_done)) begin
         check("wr_handshake_timeout", 0, 1);
         awvalid = 1'b0; wvalid = 1'b0; resp = 2'b11;
         return;
      end
      check($sformatf("wr_bvalid_latency_%0h", addr), bvalid, 1);
      resp = bresp;
      @(posedge clk); #1;
   endtask

   task automatic axi_read(input logic [AW-1:0] addr, output logic [31:0] data,
                           output logic [1:0] resp);
      bit done = 0, hit;
      araddr = addr; arvalid = 1'b1; rready = 1'b1;
      for (int i = 0; i < 20 && !done; i++) begin
         hit = arvalid && arready;
         @(posedge clk); #1;
         if (hit) begin arvalid = 1'b0; done = 1; end
      end
      if (!done) begin
         check("rd_handshake_timeout", 0, 1);
         arvalid = 1'b0; data = '0; resp = 2'b11;
         return;
      end
      check($sformatf("rd_rvalid_latency_%0h", addr), rvalid, 1);
      data = rdata;
      resp = rresp;
      @(posedge clk); #1;
   endtask

   // One channel first, then the other after 'gap' idle cycles.
   task automatic axi_write_split(input logic [AW-1:0] addr, input logic [31:0] data,
                                  input bit aw_first, input int gap);
      bit done, hit;
      bready = 1'b1; wstrb = 4'hF; awaddr = addr; wdata = data;
      for (int phase = 0; phase < 2; phase++) begin
         if ((phase == 0) == aw_first) awvalid = 1'b1;
         else                          wvalid  = 1'b1;
         done = 0;
         for (int i = 0; i < 20 && !done; i++) begin
            hit = (awvalid && awready) || (wvalid && wready);
            @(posedge clk); #1;
            if (hit) begin awvalid = 1'b0; wvalid = 1'b0; done = 1; end
         end
         if (!done) begin
            check("split_handshake_timeout", 0, 1);
            awvalid = 1'b0; wvalid = 1'b0;
            return;
         end
         if (phase == 0) begin
            for (int g = 0; g < gap; g++) begin @(posedge clk); #1; end
            check($sformatf("split_no_early_b_%0h", addr), bvalid, 0);
         end
      end
      check($sformatf("split_bvalid_%0h", addr), bvalid, 1);
      check($sformatf("split_pulse_%0h", addr), wr_pulse_o, 4'b0001 << addr[AW-1:2]);
      check($sformatf("split_bresp_%0h", addr), bresp, AXI_RESP_OKAY);
      @(posedge clk); #1;
      check($sformatf("split_pulse_gone_%0h", addr), wr_pulse_o, 0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish, got timeout, want finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [1:0]  resp;
      logic [31:0] data;
      logic [NR*32-1:0] snap;
      int unsigned sum_before, bad;

      rst_n = 1'b0;
      awaddr = '0; araddr = '0; awprot = '0; arprot = '0;
      awvalid = 0; wvalid = 0; arvalid = 0; bready = 1; rready = 1;
      wdata = '0; wstrb = '0;

      // Reset state
      repeat (3) @(posedge clk);
      #1;
      check("rst_awready", awready, 0);
      check("rst_wready", wready, 0);
      check("rst_arready", arready, 0);
      check("rst_bvalid", bvalid, 0);
      check("rst_rvalid", rvalid, 0);
      check("rst_reg_o_lo", reg_o[63:0], 0);
      check("rst_reg_o_hi", reg_o[127:64], 0);
      check("rst_pulse", wr_pulse_o, 0);
      check("rst_rdata", rdata, 0);
      check("rst_resp", {bresp, rresp}, 0);
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      check("rel_awready_before_edge", awready, 0);
      @(posedge clk); #1;
      check("rel_awready", awready, 1);
      check("rel_arready", arready, 1);

      // Sequential writes with AW and W together, then readback
      for (int i = 0; i < 4; i++) begin
         axi_write(AW'(4 * i), 32'(i + 1), 4'hF, resp);
         check($sformatf("seq_bresp_%0d", i), resp, AXI_RESP_OKAY);
      end
      for (int i = 0; i < 4; i++) begin
         axi_read(AW'(4 * i), data, resp);
         check($sformatf("seq_rdata_%0d", i), data, 32'(i + 1));
         check($sformatf("seq_rresp_%0d", i), resp, AXI_RESP_OKAY);
         check($sformatf("seq_reg_o_%0d", i), word(i), 32'(i + 1));
         check($sformatf("seq_pulse_cnt_%0d", i), pulse_cnt[i], 1);
      end

      // W three cycles ahead of AW, then AW ahead of W
      axi_write_split(6'h04, 32'hDEADBEEF, 1'b0, 2);
      check("split_w_first_reg", word(1), 32'hDEADBEEF);
      check("split_w_first_cnt", pulse_cnt[1], 2);
      axi_write_split(6'h08, 32'h0BADF00D, 1'b1, 2);
      check("split_aw_first_reg", word(2), 32'h0BADF00D);
      check("split_aw_first_cnt", pulse_cnt[2], 2);
      check("split_others_0", word(0), 32'h1);
      check("split_others_3", word(3), 32'h4);

      // Byte strobes
      axi_write(6'h00, 32'hFFFFFFFF, 4'hF, resp);
      axi_write(6'h01, 32'h12345678, 4'b0101, resp);
      axi_read(6'h00, data, resp);
      check("strb_rdata", data, 32'hFF34FF78);

      // Back-pressure, with a same-register write and read on one edge
      bready = 1'b0; rready = 1'b0;
      awaddr = 6'h00; wdata = 32'h55AA55AA; wstrb = 4'hF; araddr = 6'h00;
      check("bp_ready_all", {awready, wready, arready}, 3'b111);
      awvalid = 1'b1; wvalid = 1'b1; arvalid = 1'b1;
      @(posedge clk); #1;
      awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
      check("raw_rdata_old", rdata, 32'hFF34FF78);
      check("raw_reg_new", word(0), 32'h55AA55AA);
      bad = 0;
      for (int i = 0; i < 10; i++) begin
         if (!bvalid || !rvalid || rdata !== 32'hFF34FF78 || awready || wready || arready)
            bad++;
         @(posedge clk); #1;
      end
      check("bp_stable_cycles_bad", bad, 0);
      bready = 1'b1; rready = 1'b1;
      @(posedge clk); #1;
      check("bp_release_valids", {bvalid, rvalid}, 2'b00);
      check("bp_release_readies", {awready, arready}, 2'b11);

      // Out-of-range access
      snap = reg_o;
      sum_before = pulse_cnt[0] + pulse_cnt[1] + pulse_cnt[2] + pulse_cnt[3];
      axi_write(6'h20, 32'h13579BDF, 4'hF, resp);
      check("oor_bresp", resp, OOR_RESP);
      axi_read(6'h20, data, resp);
      check("oor_rdata", data, 0);
      check("oor_rresp", resp, OOR_RESP);
      check("oor_reg_o_lo", reg_o[63:0], snap[63:0]);
      check("oor_reg_o_hi", reg_o[127:64], snap[127:64]);
      check("oor_no_pulse", pulse_cnt[0] + pulse_cnt[1] + pulse_cnt[2] + pulse_cnt[3],
            sum_before);

      // Reset while a write response is pending
      bready = 1'b0;
      awaddr = 6'h08; wdata = 32'h77777777; wstrb = 4'hF;
      awvalid = 1'b1; wvalid = 1'b1;
      @(posedge clk); #1;
      awvalid = 1'b0; wvalid = 1'b0;
      check("mid_bvalid_pending", bvalid, 1);
      #2 rst_n = 1'b0;
      #1;
      check("mid_rst_bvalid", bvalid, 0);
      check("mid_rst_reg_o_lo", reg_o[63:0], 0);
      check("mid_rst_reg_o_hi", reg_o[127:64], 0);
      check("mid_rst_awready", awready, 0);
      @(negedge clk);
      rst_n = 1'b1;
      bready = 1'b1;
      @(posedge clk); #1;
      check("mid_rel_readies", {awready, wready, arready}, 3'b111);
      axi_write(6'h0C, 32'hA5A5A5A5, 4'hF, resp);
      check("mid_rel_bresp", resp, AXI_RESP_OKAY);
      axi_read(6'h0C, data, resp);
      check("mid_rel_rdata", data, 32'hA5A5A5A5);
      check("mid_rel_reg_o", word(3), 32'hA5A5A5A5);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/se_qubip_axil_regs.md
# se_qubip_axil_regs

AXI4-Lite slave register file forming the S00_AXI control port of the SE_QUBIP IP. It accepts host writes and reads from an AXI4-Lite master, such as the block-design master VIP or the PS. It holds a small bank of 32-bit configuration/data registers and exposes them, with per-register write pulses, to the crypto core.

## Interface
- C_S_AXI_DATA_WIDTH, 32, data bus width; only 32 is supported.
- C_S_AXI_ADDR_WIDTH, 6, byte address width.
- NUM_REGS, 4, number of implemented 32-bit registers, 1..2^(C_S_AXI_ADDR_WIDTH-2).
- s00_axi_aclk  in  1  single clock.
- s00_axi_aresetn  in  1  asynchronous, active-low reset.
- s00_axi_awaddr/awprot/awvalid/awready  in/in/in/out  ADDR_W/3/1/1  write address channel; awprot is ignored.
- s00_axi_wdata/wstrb/wvalid/wready  in/in/in/out  32/4/1/1  write data channel.
- s00_axi_bresp/bvalid/bready  out/out/in  2/1/1  write response channel.
- s00_axi_araddr/arprot/arvalid/arready  in/in/in/out  ADDR_W/3/1/1  read address channel; arprot is ignored.
- s00_axi_rdata/rresp/rvalid/rready  out/out/out/in  32/2/1/1  read data channel.
- reg_o  out  NUM_REGS*32  register contents; register k occupies bits [32k+31:32k].
- wr_pulse_o  out  NUM_REGS  one-cycle pulse on the cycle after register k is written.

## Operation
- Register index = addr[ADDR_W-1:2]; addr[1:0] are ignored. Index ≥ NUM_REGS is out of range.
- Write FSM states: IDLE, HAVE_AW, HAVE_W, RESP.
  - IDLE: awready=wready=1.
  - AW handshake alone → HAVE_AW. The address is latched and awready drops.
  - W handshake alone → HAVE_W. Data and strobe are latched and wready drops.
  - Both handshakes in the same cycle → commit, then RESP.
  - HAVE_AW + W handshake, or HAVE_W + AW handshake → commit, then RESP.
  - RESP: bvalid=1, awready=wready=0. bvalid is held until bready, then → IDLE.
- Commit:
  - Each byte lane with wstrb=1 is updated; other lanes are kept.
  - Out-of-range writes change nothing.
  - wr_pulse_o[k] is asserted for the cycle in which bvalid first rises; this fires even when wstrb=0.
- Read FSM states: IDLE (arready=1) and RVALID (arready=0).
  - AR handshake → rdata is latched from the addressed register; out-of-range reads give 0x00000000.
  - rvalid=1 is held, with stable rdata/rresp, until rready.
- Read and write are independent; both may be in flight simultaneously.
- bresp/rresp = OKAY (2'b00) unless the optional feature below is compiled in.

## Timing
- Reset (asynchronous assert, synchronous release): all registers, reg_o, wr_pulse_o, bvalid, rvalid, rdata, bresp and rresp are 0.
  - awready, wready and arready are 0 during reset and rise on the first clock edge after release.
- Reset mid-transaction: pending latched AW/W and outstanding B/R responses are discarded. The master must restart.
- Write latency: final AW/W handshake at edge n → register updated and bvalid=1 after edge n. Earliest next AW/W acceptance is one cycle after the B handshake.
- Read latency: AR handshake at edge n → rvalid=1 after edge n. Maximum throughput is one read per 2 cycles.
- Same-register read and write commit on the same edge: rdata returns the pre-write value.
- bready/rready held low: the response is held indefinitely and no new request is accepted on that path.

## Configuration
- SE_QUBIP_AXIL_SLVERR_EN defined:
  - Out-of-range write → bresp=SLVERR (2'b10), no register change, no pulse.
  - Out-of-range read → rresp=SLVERR, rdata=0.
- Not defined:
  - Out-of-range accesses respond OKAY.
  - Writes are dropped; reads return 0.

## Structure
- Package se_qubip_axil_pkg:
  - AXI_RESP_OKAY=2'b00 and AXI_RESP_SLVERR=2'b10.
  - Write-FSM and read-FSM state enum typedefs.
  - Word typedef logic [31:0].
- Single module; no sub-module warranted. The write and read FSMs are separate always_ff blocks in the same file.

## Test plan
- Sequential write of 0x1, 0x2, 0x3, 0x4 to 0x00/0x04/0x08/0x0C with AW and W together, then read back → bresp=OKAY each time, rdata 0x1..0x4, reg_o matches, wr_pulse_o pulses once per write.
- W presented 3 cycles before AW at 0x04, data 0xDEADBEEF; then AW before W at 0x08 → both commit exactly once and bvalid rises one cycle after the final handshake.
- Write 0xFFFFFFFF to 0x00, then 0x12345678 with wstrb=4'b0101 → read 0xFF34FF78.
- bready and rready held low for 10 cycles → bvalid/rvalid and rdata remain stable, awready/arready stay 0, and the response completes on release.
- Write and read 0x20:
  - With SE_QUBIP_AXIL_SLVERR_EN: bresp=rresp=2'b10, rdata=0, reg_o unchanged.
  - Without it: OKAY responses, rdata=0.
- Assert s00_axi_aresetn low while bvalid is pending → bvalid=0 and reg_o=0 immediately. After release, ready signals return and a write/readback of 0xA5A5A5A5 to 0x0C passes.
